// File: rtl/tosam_pkg.sv
// rtl/tosam_pkg.sv - shared constants and helpers for the tosam_pipe approximate multiplier
package tosam_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_H     = 1;
    localparam int DEF_T     = 5;

    // Bits needed to hold a leading-one index 0..width-1
    function automatic int k_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

    // Legal parameter space of the multiplier
    function automatic bit params_ok(input int width, input int h, input int t, input int tag_w);
        return (width >= 4) && (width <= 32) && (h >= 1) && (h <= t) &&
               (t <= width - 1) && (tag_w >= 1);
    endfunction

endpackage

// File: rtl/tosam_lod.sv
// rtl/tosam_lod.sv - leading-one detector and left-aligned fraction extractor
module tosam_lod
    import tosam_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int T     = DEF_T
) (
    input  logic [WIDTH-1:0]            x,
    output logic [k_width(WIDTH)-1:0]   k,
    output logic [T-1:0]                y,
    output logic                        zero
);

    localparam int KW = k_width(WIDTH);

    logic [KW-1:0]    sh;
    logic [WIDTH-2:0] norm;

    // Find the highest set bit, then shift it out so the bits below it are left-aligned
    always_comb begin
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) k = i[KW-1:0];
        end
        sh   = KW'(WIDTH - 1) - k;
        norm = (WIDTH-1)'(x << sh);
        y    = T'(norm >> (WIDTH - 1 - T));
        zero = (x == '0);
    end

endmodule

// File: rtl/tosam_pipe.sv
// rtl/tosam_pipe.sv - 3-stage TOSAM approximate multiplier; TOSAM_EXACT_EN adds per-transaction exact mode
module tosam_pipe
    import tosam_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int H     = DEF_H,
    parameter int T     = DEF_T,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [TAG_W-1:0]     in_tag,
`ifdef TOSAM_EXACT_EN
    input  logic                 in_exact,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int KW  = k_width(WIDTH);
    localparam int SW  = KW + 1;
    localparam int MW  = T + 2;
    localparam int CP  = 2 * H + 2;
    localparam int LSH = (T > CP) ? T - CP : 0;
    localparam int RSH = (CP > T) ? CP - T : 0;

    if (!params_ok(WIDTH, H, T, TAG_W)) begin : g_bad_params
        $error("tosam_pipe: illegal WIDTH/H/T/TAG_W combination");
    end

    logic adv;
    logic [KW-1:0] ka, kb;
    logic [T-1:0]  ya, yb;
    logic          za, zb;

    tosam_lod #(.WIDTH(WIDTH), .T(T)) u_lod_a (.x(in_a), .k(ka), .y(ya), .zero(za));
    tosam_lod #(.WIDTH(WIDTH), .T(T)) u_lod_b (.x(in_b), .k(kb), .y(yb), .zero(zb));

    logic s1_v_q, s1_v_d, s1_zero_q, s1_zero_d;
    logic [KW-1:0] s1_ka_q, s1_ka_d, s1_kb_q, s1_kb_d;
    logic [T-1:0]  s1_ya_q, s1_ya_d, s1_yb_q, s1_yb_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d, out_tag_q, out_tag_d;
    logic s2_v_q, s2_v_d, s2_zero_q, s2_zero_d, out_v_q, out_v_d;
    logic [MW-1:0] s2_m_q, s2_m_d;
    logic [SW-1:0] s2_ks_q, s2_ks_d;
    logic [2*WIDTH-1:0] out_p_q, out_p_d;
    logic [H:0]      ha_n, hb_n;
    logic [CP-1:0]   cross_full;
    logic [CP+T-1:0] cross_w;
    logic [T-1:0]    cross_t;
    logic [T+2*WIDTH-1:0] wide;
`ifdef TOSAM_EXACT_EN
    logic s1_ex_q, s1_ex_d, s2_ex_q, s2_ex_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [2*WIDTH-1:0] s2_prod_q, s2_prod_d;
`endif

    assign adv       = out_ready | ~out_v_q;
    assign in_ready  = adv;
    assign out_valid = out_v_q;
    assign out_p     = out_p_q;
    assign out_tag   = out_tag_q;

    // S1: capture leading-one positions and linear fractions of an accepted input
    always_comb begin
        s1_v_d    = in_valid;
        s1_ka_d   = ka;
        s1_kb_d   = kb;
        s1_ya_d   = ya;
        s1_yb_d   = yb;
        s1_zero_d = za | zb;
        s1_tag_d  = in_tag;
`ifdef TOSAM_EXACT_EN
        s1_ex_d   = in_exact;
        s1_a_d    = in_a;
        s1_b_d    = in_b;
`endif
    end

    // S2: mantissa 1 + YA + YB + ha*hb, all scaled by 2^T into T+2 bits
    always_comb begin
        ha_n       = {s1_ya_q[T-1 -: H], 1'b1};
        hb_n       = {s1_yb_q[T-1 -: H], 1'b1};
        cross_full = CP'(ha_n) * CP'(hb_n);
        cross_w    = (CP+T)'(cross_full);
        cross_t    = T'((cross_w << LSH) >> RSH);
        s2_v_d     = s1_v_q;
        s2_m_d     = {2'b01, {T{1'b0}}} + MW'(s1_ya_q) + MW'(s1_yb_q) + MW'(cross_t);
        s2_ks_d    = SW'(s1_ka_q) + SW'(s1_kb_q);
        s2_zero_d  = s1_zero_q;
        s2_tag_d   = s1_tag_q;
`ifdef TOSAM_EXACT_EN
        s2_ex_d    = s1_ex_q;
        s2_prod_d  = (2*WIDTH)'(s1_a_q) * (2*WIDTH)'(s1_b_q);
`endif
    end

    // S3: scale mantissa by 2^(KA+KB), drop the T fraction bits, force zero operands to 0
    always_comb begin
        wide      = (T+2*WIDTH)'(s2_m_q) << s2_ks_q;
        out_p_d   = s2_zero_q ? '0 : (2*WIDTH)'(wide >> T);
`ifdef TOSAM_EXACT_EN
        if (s2_ex_q) out_p_d = s2_prod_q;
`endif
        out_v_d   = s2_v_q;
        out_tag_d = s2_tag_q;
    end

    // All stages move together only when the output slot is free or being drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0; s1_zero_q <= 1'b0; s1_ka_q <= '0; s1_kb_q <= '0;
            s1_ya_q <= '0; s1_yb_q <= '0; s1_tag_q <= '0;
            s2_v_q <= 1'b0; s2_zero_q <= 1'b0; s2_m_q <= '0; s2_ks_q <= '0; s2_tag_q <= '0;
            out_v_q <= 1'b0; out_p_q <= '0; out_tag_q <= '0;
`ifdef TOSAM_EXACT_EN
            s1_ex_q <= 1'b0; s1_a_q <= '0; s1_b_q <= '0; s2_ex_q <= 1'b0; s2_prod_q <= '0;
`endif
        end else if (adv) begin
            s1_v_q <= s1_v_d; s1_zero_q <= s1_zero_d; s1_ka_q <= s1_ka_d; s1_kb_q <= s1_kb_d;
            s1_ya_q <= s1_ya_d; s1_yb_q <= s1_yb_d; s1_tag_q <= s1_tag_d;
            s2_v_q <= s2_v_d; s2_zero_q <= s2_zero_d; s2_m_q <= s2_m_d; s2_ks_q <= s2_ks_d;
            s2_tag_q <= s2_tag_d;
            out_v_q <= out_v_d; out_p_q <= out_p_d; out_tag_q <= out_tag_d;
`ifdef TOSAM_EXACT_EN
            s1_ex_q <= s1_ex_d; s1_a_q <= s1_a_d; s1_b_q <= s1_b_d; s2_ex_q <= s2_ex_d;
            s2_prod_q <= s2_prod_d;
`endif
        end
    end

endmodule

// File: tb/tb_tosam_pipe.sv
// tb/tb_tosam_pipe.sv - self-checking bench for tosam_pipe against a real-arithmetic reference model
module tb_tosam_pipe;
    import tosam_pkg::*;

    localparam int W  = 8;
    localparam int HP = 1;
    localparam int TP = 5;
    localparam int TW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready, out_valid, out_ready, in_exact;
    logic [W-1:0]    in_a, in_b;
    logic [TW-1:0]   in_tag, out_tag;
    logic [2*W-1:0]  out_p;

    int       vectors = 0;
    int       miscompares = 0;
    int       out_count = 0;
    bit       accepted;
    longint   exp_p_q[$];
    int       exp_tag_q[$];

    always #5 clk = ~clk;

    tosam_pipe #(.WIDTH(W), .H(HP), .T(TP), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
`ifdef TOSAM_EXACT_EN
        .in_exact(in_exact),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_tag(out_tag)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // floor((1 + YA/2^T + YB/2^T + ha*hb) * 2^(KA+KB)) evaluated with reals
    function automatic longint model(input int a, input int b, input bit ex);
        int  ka, kb, ya, yb;
        real ha, hb, m;
        if (ex) return longint'(a) * longint'(b);
        if (a == 0 || b == 0) return 0;
        ka = 0; kb = 0;
        for (int i = 0; i < W; i++) begin
            if (a >= (1 << i)) ka = i;
            if (b >= (1 << i)) kb = i;
        end
        ya = ((a - (1 << ka)) * (1 << TP)) / (1 << ka);
        yb = ((b - (1 << kb)) * (1 << TP)) / (1 << kb);
        ha = real'((ya / (1 << (TP - HP))) * 2 + 1) / real'(1 << (HP + 1));
        hb = real'((yb / (1 << (TP - HP))) * 2 + 1) / real'(1 << (HP + 1));
        m  = 1.0 + real'(ya) / real'(1 << TP) + real'(yb) / real'(1 << TP) + ha * hb;
        return longint'($floor(m * (2.0 ** (ka + kb))));
    endfunction

    // One clock: score any output handshake, record any accept, return at the next falling edge
    task automatic cycle();
        #1;
        accepted = in_valid && in_ready;
        if (out_valid && out_ready) begin
            out_count++;
            if (exp_p_q.size() == 0) begin
                check("unexpected_output", 64'(out_valid), 64'd0);
            end else begin
                check("out_p", 64'(out_p), 64'(exp_p_q.pop_front()));
                check("out_tag", 64'(out_tag), 64'(exp_tag_q.pop_front()));
            end
        end
        @(posedge clk);
        if (accepted) begin
            exp_p_q.push_back(model(int'(in_a), int'(in_b), in_exact));
            exp_tag_q.push_back(int'(in_tag));
        end
        @(negedge clk);
    endtask

    task automatic send(input int a, input int b, input int tag, input bit ex);
        in_a = W'(a); in_b = W'(b); in_tag = TW'(tag); in_exact = ex; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (accepted) break;
        end
        if (!accepted) check("accept_timeout", 64'(accepted), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 50 && exp_p_q.size() > 0; i++) cycle();
        check("drain_empty", 64'(exp_p_q.size()), 64'd0);
    endtask

    task automatic run_one(input int a, input int b, input bit ex, input longint lit);
        int i;
        send(a, b, 5, ex);
        for (i = 0; i < 10 && !out_valid; i++) cycle();
        check($sformatf("lit_%0dx%0d", a, b), 64'(out_p), 64'(lit));
        drain();
    endtask

    logic [2*W-1:0] held_p;
    logic [TW-1:0]  held_tag;
    int             idx, base;
    int             sa[8], sb[8];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
        in_exact = 1'b0; out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_p", 64'(out_p), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // first accept right after release, then exact 3-cycle latency
        rst_n = 1'b1;
        in_a = 8'd3; in_b = 8'd5; in_tag = 4'd2; in_valid = 1'b1;
        cycle();
        check("first_accept", 64'(accepted), 64'd1);
        in_valid = 1'b0;
        check("lat1_valid", 64'(out_valid), 64'd0);
        cycle();
        check("lat2_valid", 64'(out_valid), 64'd0);
        cycle();
        check("lat3_valid", 64'(out_valid), 64'd1);
        check("lat3_p", 64'(out_p), 64'd15);
        check("lat3_tag", 64'(out_tag), 64'd2);
        drain();

        run_one(255, 255, 1'b0, 57344);
        run_one(128, 128, 1'b0, 17408);
        run_one(1, 1, 1'b0, 1);
        run_one(0, 200, 1'b0, 0);
        run_one(77, 0, 1'b0, 0);

        // back-to-back stream with a 4-cycle output stall in the middle
        for (int i = 0; i < 8; i++) begin
            sa[i] = int'($urandom_range(1, 255));
            sb[i] = int'($urandom_range(1, 255));
        end
        base = out_count; idx = 0;
        for (int c = 0; c < 60; c++) begin
            if (idx >= 8 && exp_p_q.size() == 0) break;
            out_ready = !(c >= 5 && c < 9);
            if (idx < 8) begin
                in_a = W'(sa[idx]); in_b = W'(sb[idx]); in_tag = TW'(idx + 8); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (!out_ready) begin
                #1;
                check("stall_in_ready", 64'(in_ready), 64'd0);
                if (c == 5) begin
                    held_p = out_p; held_tag = out_tag;
                end else begin
                    check("stall_hold_p", 64'(out_p), 64'(held_p));
                    check("stall_hold_tag", 64'(out_tag), 64'(held_tag));
                end
            end
            cycle();
            if (accepted) idx++;
        end
        check("stream_count", 64'(out_count - base), 64'd8);
        drain();

        // reset with three transactions in flight
        out_ready = 1'b0;
        send(10, 20, 1, 1'b0);
        send(30, 40, 2, 1'b0);
        send(50, 60, 3, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_p", 64'(out_p), 64'd0);
        exp_p_q.delete(); exp_tag_q.delete();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("post_rst_no_stale", 64'(out_valid), 64'd0);
        end

`ifdef TOSAM_EXACT_EN
        run_one(255, 255, 1'b1, 65025);
        send(255, 255, 6, 1'b1);
        send(255, 255, 7, 1'b0);
        send(255, 255, 8, 1'b1);
        drain();
`endif

        // randomized full-range traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_a = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
            in_b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
            in_tag = TW'($urandom);
`ifdef TOSAM_EXACT_EN
            in_exact = 1'($urandom);
`endif
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
